// File: rtl/me_unit.sv
`default_nettype none
// ============================================================================
// Module   : me_unit
// Purpose  : Memory-access stage of the 5-stage LoongArch pipeline. Issues
//            loads/stores on an SRAM-like req/addr_ok/data_ok bus, aligns
//            and extends load data, and forwards results to WB and ID.
// Revision : 1.0 - initial release
// ============================================================================
module me_unit #(
    parameter int EX_to_ME_Bus_Size = 107,
    parameter int ME_to_WB_Bus_Size = 70
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         EX_to_ME_Valid,
    input  logic [EX_to_ME_Bus_Size-1:0] EX_to_ME_Bus,
    output logic                         ME_Allow_in,
    output logic                         ME_to_WB_Valid,
    output logic [ME_to_WB_Bus_Size-1:0] ME_to_WB_Bus,
    input  logic                         WB_Allow_in,
    output logic                         data_sram_req,
    output logic                         data_sram_wr,
    output logic [1:0]                   data_sram_size,
    output logic [3:0]                   data_sram_wstrb,
    output logic [31:0]                  data_sram_addr,
    output logic [31:0]                  data_sram_wdata,
    input  logic                         data_sram_addr_ok,
    input  logic                         data_sram_data_ok,
    input  logic [31:0]                  data_sram_rdata,
    output logic [4:0]                   ME_dest,
    output logic [31:0]                  ME_Forward_Res,
    output logic                         ME_load_pending
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic                           valid_q, valid_d;
    logic [EX_to_ME_Bus_Size-1:0]   bus_q,   bus_d;
    logic [31:0]                    rdata_q, rdata_d;

    // Fields of the latched instruction
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  mem_op;
    logic [31:0] store_data;

    assign pc         = bus_q[106:75];
    assign gr_we      = bus_q[74];
    assign dest       = bus_q[73:69];
    assign alu_result = bus_q[68:37];
    assign mem_re     = bus_q[36];
    assign mem_we     = bus_q[35];
    assign mem_op     = bus_q[34:32];
    assign store_data = bus_q[31:0];

    logic ready_go;
    logic latch;
    logic in_is_mem;
    logic [31:0] load_result;
    logic [31:0] final_result;

    // A memory instruction may only leave once its response is buffered
    assign ready_go    = !(mem_re || mem_we) || (state_q == S_DONE);
    assign ME_Allow_in = !valid_q || (ready_go && WB_Allow_in);
    assign latch       = EX_to_ME_Valid && ME_Allow_in;
    assign in_is_mem   = EX_to_ME_Bus[36] || EX_to_ME_Bus[35];

    assign ME_to_WB_Valid  = valid_q && ready_go;
    assign ME_to_WB_Bus    = {pc, gr_we, dest, final_result};
    assign ME_dest         = dest & {5{gr_we && valid_q}};
    assign ME_Forward_Res  = final_result;
    assign ME_load_pending = valid_q && mem_re && (state_q != S_DONE);

    // Request fields come straight from the latched payload, which cannot
    // change while the request is outstanding because ME_Allow_in is low.
    assign data_sram_req  = (state_q == S_REQ);
    assign data_sram_wr   = mem_we;
    assign data_sram_size = mem_op[1:0];
    assign data_sram_addr = alu_result;

    // Store byte enables and lane-replicated write data
    always_comb begin
        data_sram_wstrb = 4'b0000;
        data_sram_wdata = store_data;
        case (mem_op[1:0])
            2'd0: begin
                data_sram_wstrb = 4'b0001 << alu_result[1:0];
                data_sram_wdata = {4{store_data[7:0]}};
            end
            2'd1: begin
                data_sram_wstrb = alu_result[1] ? 4'b1100 : 4'b0011;
                data_sram_wdata = {2{store_data[15:0]}};
            end
            default: begin
                data_sram_wstrb = 4'b1111;
                data_sram_wdata = store_data;
            end
        endcase
        if (!mem_we) begin
            data_sram_wstrb = 4'b0000;
        end
    end

    // Lane selection and sign/zero extension of the buffered load word
    always_comb begin
        logic [7:0]  ld_byte;
        logic [15:0] ld_half;
        ld_byte     = rdata_q[8*alu_result[1:0] +: 8];
        ld_half     = alu_result[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (mem_op)
            3'd0:    load_result = {{24{ld_byte[7]}}, ld_byte};
            3'd4:    load_result = {24'd0, ld_byte};
            3'd1:    load_result = {{16{ld_half[15]}}, ld_half};
            3'd5:    load_result = {16'd0, ld_half};
            default: load_result = rdata_q;
        endcase
        final_result = mem_re ? load_result : alu_result;
    end

    // Next-state: handshake, payload latch and memory-transaction sequencing
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        bus_d   = bus_q;
        rdata_d = rdata_q;
        if (ME_Allow_in) begin
            valid_d = EX_to_ME_Valid;
        end
        if (latch) begin
            bus_d = EX_to_ME_Bus;
        end
        case (state_q)
            S_IDLE: if (latch && in_is_mem) state_d = S_REQ;
            S_REQ:  if (data_sram_addr_ok) state_d = S_WAIT;
            S_WAIT: begin
                if (data_sram_data_ok) begin
                    state_d = S_DONE;
                    rdata_d = data_sram_rdata;
                end
            end
            S_DONE: begin
                // A back-to-back memory instruction goes straight to REQ
                if (ready_go && WB_Allow_in) begin
                    state_d = (latch && in_is_mem) ? S_REQ : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; async reset abandons any in-flight transaction
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            bus_q   <= '0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            bus_q   <= bus_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_me_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_me_unit
// Purpose  : Self-checking bench for me_unit: directed scenarios followed by
//            randomized instructions checked against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_me_unit;

    logic         clk = 1'b0;
    logic         resetn;
    logic         EX_to_ME_Valid;
    logic [106:0] EX_to_ME_Bus;
    logic         ME_Allow_in;
    logic         ME_to_WB_Valid;
    logic [69:0]  ME_to_WB_Bus;
    logic         WB_Allow_in;
    logic         data_sram_req;
    logic         data_sram_wr;
    logic [1:0]   data_sram_size;
    logic [3:0]   data_sram_wstrb;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         data_sram_addr_ok;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic [4:0]   ME_dest;
    logic [31:0]  ME_Forward_Res;
    logic         ME_load_pending;

    int n_assert = 0;
    int n_fail   = 0;

    me_unit #(
        .EX_to_ME_Bus_Size (107),
        .ME_to_WB_Bus_Size (70)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .EX_to_ME_Valid    (EX_to_ME_Valid),
        .EX_to_ME_Bus      (EX_to_ME_Bus),
        .ME_Allow_in       (ME_Allow_in),
        .ME_to_WB_Valid    (ME_to_WB_Valid),
        .ME_to_WB_Bus      (ME_to_WB_Bus),
        .WB_Allow_in       (WB_Allow_in),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ME_dest           (ME_dest),
        .ME_Forward_Res    (ME_Forward_Res),
        .ME_load_pending   (ME_load_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Architectural load semantics: pick the addressed byte/half and extend
    function automatic logic [31:0] model_result(input logic re, input logic [2:0] op,
                                                 input logic [31:0] addr, input logic [31:0] rd);
        int unsigned u;
        int          s;
        if (!re) return addr;
        case (op)
            3'd0, 3'd4: begin
                u = (rd >> (8 * addr[1:0])) % 256;
                s = (op == 3'd0 && u >= 128) ? int'(u) - 256 : int'(u);
            end
            3'd1, 3'd5: begin
                u = (rd >> (16 * addr[1])) % 65536;
                s = (op == 3'd1 && u >= 32768) ? int'(u) - 65536 : int'(u);
            end
            default: s = int'(rd);
        endcase
        return 32'(s);
    endfunction

    function automatic logic [3:0] model_wstrb(input logic we, input logic [2:0] op,
                                               input logic [31:0] addr);
        int a;
        a = int'(addr[1:0]);
        if (!we) return 4'd0;
        case (op[1:0])
            2'd0:    return 4'(1 << a);
            2'd1:    return 4'(3 << (a - a % 2));
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] d);
        case (op[1:0])
            2'd0:    return (d % 256) * 32'h01010101;
            2'd1:    return (d % 65536) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    // Present one instruction, serve its memory access with the given
    // addr_ok/data_ok delays, and hold WB off for bp cycles at the end.
    task automatic do_instr(input logic [31:0] pc, input logic gw, input logic [4:0] dst,
                            input logic [31:0] alu, input logic re, input logic we,
                            input logic [2:0] op, input logic [31:0] sd,
                            input int ao_dly, input int do_dly, input int bp,
                            input logic [31:0] rd);
        logic [31:0] exp_res;
        int          guard;
        exp_res        = model_result(re, op, alu, rd);
        EX_to_ME_Bus   = {pc, gw, dst, alu, re, we, op, sd};
        EX_to_ME_Valid = 1'b1;
        WB_Allow_in    = (bp == 0);
        settle();
        guard = 0;
        while (!ME_Allow_in && guard < 50) begin
            tick(); settle(); guard++;
        end
        chk("accept", 70'(ME_Allow_in), 70'(1));
        tick();
        EX_to_ME_Valid = 1'b0;
        settle();
        if (re || we) begin
            for (int i = 0; i <= ao_dly; i++) begin
                chk("req",        70'(data_sram_req),   70'(1));
                chk("addr",       70'(data_sram_addr),  70'(alu));
                chk("size",       70'(data_sram_size),  70'(op % 4));
                chk("wr",         70'(data_sram_wr),    70'(we));
                chk("wstrb",      70'(data_sram_wstrb), 70'(model_wstrb(we, op, alu)));
                if (we) chk("wdata", 70'(data_sram_wdata), 70'(model_wdata(op, sd)));
                chk("allow_req",  70'(ME_Allow_in),     70'(0));
                chk("pend_req",   70'(ME_load_pending), 70'(re));
                chk("wbv_req",    70'(ME_to_WB_Valid),  70'(0));
                data_sram_addr_ok = (i == ao_dly);
                tick(); settle();
            end
            data_sram_addr_ok = 1'b0;
            for (int i = 0; i <= do_dly; i++) begin
                chk("req_wait",   70'(data_sram_req),   70'(0));
                chk("pend_wait",  70'(ME_load_pending), 70'(re));
                chk("allow_wait", 70'(ME_Allow_in),     70'(0));
                data_sram_data_ok = (i == do_dly);
                data_sram_rdata   = (i == do_dly) ? rd : $urandom;
                tick(); settle();
            end
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = $urandom;
        end
        for (int i = 0; i <= bp; i++) begin
            WB_Allow_in = (i == bp);
            #1;
            chk("wb_valid",  70'(ME_to_WB_Valid),  70'(1));
            chk("wb_bus",    70'(ME_to_WB_Bus),    {pc, gw, dst, exp_res});
            chk("fwd_res",   70'(ME_Forward_Res),  70'(exp_res));
            chk("fwd_dest",  70'(ME_dest),         70'(gw ? dst : 5'd0));
            chk("pend_done", 70'(ME_load_pending), 70'(0));
            chk("req_done",  70'(data_sram_req),   70'(0));
            chk("allow_out", 70'(ME_Allow_in),     70'(i == bp));
            tick(); settle();
        end
        WB_Allow_in = 1'b1;
        chk("wb_empty", 70'(ME_to_WB_Valid), 70'(0));
    endtask

    logic [2:0]  ld_ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [31:0] exp_a;
    int          guard;

    initial begin
        resetn            = 1'b0;
        EX_to_ME_Valid    = 1'b0;
        EX_to_ME_Bus      = '0;
        WB_Allow_in       = 1'b1;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        #3;
        chk("rst_wbv",   70'(ME_to_WB_Valid),  70'(0));
        chk("rst_req",   70'(data_sram_req),   70'(0));
        chk("rst_dest",  70'(ME_dest),         70'(0));
        chk("rst_pend",  70'(ME_load_pending), 70'(0));
        chk("rst_allow", 70'(ME_Allow_in),     70'(1));
        tick(); tick();
        resetn = 1'b1;
        tick();

        // ALU pass-through
        do_instr(32'h1c000000, 1'b1, 5'd5, 32'h12345678, 1'b0, 1'b0, 3'd0, 32'd0, 0, 0, 0, 32'd0);
        // Byte loads, signed and unsigned, minimum latency
        do_instr(32'h1c000004, 1'b1, 5'd6, 32'h00001003, 1'b1, 1'b0, 3'd0, 32'd0, 0, 0, 0, 32'h80FF0011);
        do_instr(32'h1c000008, 1'b1, 5'd7, 32'h00001003, 1'b1, 1'b0, 3'd4, 32'd0, 0, 0, 0, 32'h80FF0011);
        // Half loads with a slower response
        do_instr(32'h1c00000c, 1'b1, 5'd8, 32'h00002002, 1'b1, 1'b0, 3'd1, 32'd0, 1, 2, 0, 32'h80017FFF);
        do_instr(32'h1c000010, 1'b1, 5'd9, 32'h00002002, 1'b1, 1'b0, 3'd5, 32'd0, 0, 1, 0, 32'h80017FFF);
        // Byte store with addr_ok delayed three cycles
        do_instr(32'h1c000014, 1'b0, 5'd0, 32'h00003001, 1'b0, 1'b1, 3'd0, 32'hAABBCCDD, 3, 0, 0, 32'd0);
        // Word load held by WB for four cycles
        do_instr(32'h1c000018, 1'b1, 5'd10, 32'h00004000, 1'b1, 1'b0, 3'd2, 32'd0, 0, 0, 4, 32'hCAFEF00D);

        // Back-to-back loads with backpressure on the first result
        EX_to_ME_Bus   = {32'h1c000020, 1'b1, 5'd11, 32'h00005001, 1'b1, 1'b0, 3'd0, 32'd0};
        EX_to_ME_Valid = 1'b1;
        WB_Allow_in    = 1'b0;
        settle();
        tick();
        EX_to_ME_Bus      = {32'h1c000024, 1'b1, 5'd12, 32'h00006002, 1'b1, 1'b0, 3'd5, 32'd0};
        data_sram_addr_ok = 1'b1;
        settle();
        tick();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1234A5C3;
        settle();
        tick();
        data_sram_data_ok = 1'b0;
        exp_a = model_result(1'b1, 3'd0, 32'h00005001, 32'h1234A5C3);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("b2b_hold_v",   70'(ME_to_WB_Valid), 70'(1));
            chk("b2b_hold_res", 70'(ME_Forward_Res), 70'(exp_a));
            chk("b2b_hold_req", 70'(data_sram_req),  70'(0));
            chk("b2b_hold_al",  70'(ME_Allow_in),    70'(0));
            tick();
        end
        WB_Allow_in = 1'b1;
        settle();
        chk("b2b_handoff", 70'(ME_Allow_in), 70'(1));
        chk("b2b_res_a",   70'(ME_to_WB_Bus), {32'h1c000020, 1'b1, 5'd11, exp_a});
        tick();
        EX_to_ME_Valid = 1'b0;
        settle();
        chk("b2b_req",      70'(data_sram_req),   70'(1));
        chk("b2b_addr",     70'(data_sram_addr),  70'(32'h00006002));
        chk("b2b_wbv",      70'(ME_to_WB_Valid),  70'(0));
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBEEF0000;
        settle();
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        chk("b2b_res_b", 70'(ME_to_WB_Bus),
            {32'h1c000024, 1'b1, 5'd12, model_result(1'b1, 3'd5, 32'h00006002, 32'hBEEF0000)});
        tick();
        settle();
        chk("b2b_empty", 70'(ME_to_WB_Valid), 70'(0));

        // Reset asserted while the load waits for data_ok
        EX_to_ME_Bus   = {32'h1c000030, 1'b1, 5'd13, 32'h00007000, 1'b1, 1'b0, 3'd2, 32'd0};
        EX_to_ME_Valid = 1'b1;
        settle();
        tick();
        EX_to_ME_Valid    = 1'b0;
        data_sram_addr_ok = 1'b1;
        settle();
        tick();
        data_sram_addr_ok = 1'b0;
        settle();
        chk("rw_pend", 70'(ME_load_pending), 70'(1));
        resetn = 1'b0;
        #1;
        chk("rw_wbv",   70'(ME_to_WB_Valid),  70'(0));
        chk("rw_req",   70'(data_sram_req),   70'(0));
        chk("rw_pend0", 70'(ME_load_pending), 70'(0));
        chk("rw_allow", 70'(ME_Allow_in),     70'(1));
        tick();
        resetn            = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h55555555;
        settle();
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        chk("rw_late_wbv", 70'(ME_to_WB_Valid), 70'(0));
        chk("rw_late_req", 70'(data_sram_req),  70'(0));

        // Randomized instruction mix
        for (int n = 0; n < 40; n++) begin
            int          kind;
            logic [2:0]  op;
            logic        re, we, gw;
            kind = int'($urandom_range(0, 2));
            re   = (kind == 1);
            we   = (kind == 2);
            op   = re ? ld_ops[$urandom_range(0, 4)] : (we ? 3'($urandom_range(0, 2)) : 3'd0);
            gw   = we ? 1'b0 : 1'($urandom_range(0, 1));
            do_instr($urandom, gw, 5'($urandom), $urandom, re, we, op, $urandom,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)), $urandom);
        end

        guard = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/me_unit.md
Name: me_unit

Overview:
- Memory-access pipeline stage of the 5-stage LoongArch core, between the execute stage and the write-back stage.
- Accepts one instruction per handshake from execute and issues its load/store on the SRAM-like data bus (req/addr_ok/data_ok).
- Waits for the response, then aligns and extends load data.
- Hands {pc, gr_we, dest, final_result} to write-back, and exports dest/result for ID-stage forwarding and load-use stall detection.

Parameters:
EX_to_ME_Bus_Size, 107, width of input bus: {pc[106:75], gr_we[74], dest[73:69], alu_result[68:37], mem_re[36], mem_we[35], mem_op[34:32], store_data[31:0]}
ME_to_WB_Bus_Size, 70, width of output bus: {pc[69:38], gr_we[37], dest[36:32], final_result[31:0]}

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
EX_to_ME_Valid  input  1  execute stage holds valid instruction
EX_to_ME_Bus  input  107  instruction payload
ME_Allow_in  output  1  stage can accept this cycle
ME_to_WB_Valid  output  1  result valid toward write-back
ME_to_WB_Bus  output  70  result payload
WB_Allow_in  input  1  write-back can accept
data_sram_req  output  1  memory request
data_sram_wr  output  1  1=store, 0=load
data_sram_size  output  2  0=byte, 1=half, 2=word
data_sram_wstrb  output  4  byte enables (stores)
data_sram_addr  output  32  byte address
data_sram_wdata  output  32  store data, lane-replicated
data_sram_addr_ok  input  1  request accepted
data_sram_data_ok  input  1  response/write-ack
data_sram_rdata  input  32  load data
ME_dest  output  5  forwarding dest, 0 when no write
ME_Forward_Res  output  32  forwarding value
ME_load_pending  output  1  valid load not yet returned (ID must stall)

Behaviour:
- Reset (resetn low, async): Valid=0, state=IDLE, rdata buffer=0. All outputs 0: req, ME_to_WB_Valid, ME_dest, ME_load_pending.
- mem_op encoding: 0 b, 1 h, 2 w, 4 bu, 5 hu. Store uses only 0/1/2. mem_re and mem_we are never both 1.
- Payload latch: when EX_to_ME_Valid && ME_Allow_in. Valid <= EX_to_ME_Valid whenever ME_Allow_in.
- ReadyGo = !(mem_re||mem_we) || state==DONE.
- ME_Allow_in = !Valid || (ReadyGo && WB_Allow_in).
- ME_to_WB_Valid = Valid && ReadyGo.
- FSM:
  - IDLE: on latch of a mem instruction -> REQ.
  - REQ: req=1 -> WAIT on addr_ok.
  - WAIT: -> DONE on data_ok, capturing rdata into buffer.
  - DONE: on handoff (ReadyGo && WB_Allow_in) -> REQ if a new mem instruction is latched that cycle, else IDLE.
  - Non-mem instructions pass in 0 extra cycles.
- Request rules:
  - req asserted only in REQ.
  - addr/size/wr/wstrb/wdata are held stable from REQ until addr_ok.
  - Minimum latency is 2 cycles from latch (addr_ok same cycle as req, data_ok next cycle).
- Bus contract: data_ok never arrives in the same cycle as its addr_ok. data_ok in IDLE/REQ/DONE is ignored.
- Address = alu_result. Size from mem_op[1:0].
- Store wstrb:
  - b: 4'b0001<<addr[1:0]
  - h: addr[1]?1100:0011
  - w: 1111
  - wdata replicated: b {4{d[7:0]}}, h {2{d[15:0]}}, w d.
  - wstrb=0 for loads.
- Load result from buffer by addr[1:0]:
  - b/bu: byte at lane addr[1:0], sign/zero extend.
  - h/hu: half at addr[1], sign/zero extend.
  - w: whole word.
  - Misalignment is not checked; the low address bits select the lane as above.
- final_result = load result if mem_re, else alu_result. Stores still output gr_we from the bus (0 by decode).
- ME_dest = dest & {5{gr_we && Valid}}. ME_Forward_Res = final_result.
- ME_load_pending = Valid && mem_re && state!=DONE.
- Backpressure in DONE: buffered data is held indefinitely until WB_Allow_in. No new request is issued.
- Reset mid-transaction: everything clears. The response of the abandoned transaction is ignored.

Test Plan:
- ALU pass-through: bus pc=0x1c000000, gr_we=1, dest=5, alu_result=0x12345678, WB_Allow_in=1. Next cycle ME_to_WB_Bus={0x1c000000,1,5,0x12345678} and ME_to_WB_Valid=1. No req.
- ld.b at addr 0x1003, rdata=0x80FF0011: req with size=0, addr=0x1003. addr_ok same cycle, data_ok next cycle. final_result=0xFFFFFF80. ld.bu at same addr gives 0x00000080.
- ld.h at 0x2002, rdata=0x8001_7FFF: final 0xFFFF8001. ld.hu gives 0x00008001. ME_load_pending=1 until DONE, then 0.
- st.b at 0x3001, store_data=0xAABBCCDD: wstrb=0010, wdata=0xDDDDDDDD, wr=1. addr_ok delayed 3 cycles: outputs stable throughout, ME_Allow_in=0 until data_ok.
- Backpressure: load completes while WB_Allow_in=0 for 4 cycles. Result held, state DONE, no new req. Back-to-back mem instructions after release: REQ re-entered in the handoff cycle.
- resetn pulled low in WAIT: Valid=0, req=0, IDLE. A late data_ok is ignored and ME_to_WB_Valid stays 0.
